mc_pricing_ctrl: RTL and testbench
==================================

# mc_pricing_ctrl

Parametrised control and accumulation core for the Monte-Carlo option-pricing engine. It loads the pricing configuration over a narrow command/data port and starts the Sobol/path-generation/pricing datapath. It then accumulates LANES payoffs per beat over 2^log2_paths paths and returns their mean as the option price. It replaces the fixed single-lane top-level controller and adds lane parallelism, a configurable path count, abort and a done handshake.

## Interface
- LANES, 4: payoff lanes per beat; power of two, ≥1. LG_L = clog2(LANES).
- IN_W, 12: configuration word width.
- PAY_W, 16: unsigned payoff width per lane; also the price width.
- LOG2_MAX, 16: maximum log2 of the path count.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd  in  2  00 NOP, 01 LOAD, 10 START, 11 ABORT; sampled every cycle.
- cfg_in  in  IN_W  LOAD data.
- pay_valid  in  1  all lanes of pay_data valid this cycle.
- pay_data  in  LANES*PAY_W  lane i at bits [i*PAY_W +: PAY_W]; unsigned.
- cfg_spot, cfg_strike, cfg_vol  out  IN_W each  config registers driven to the datapath.
- gen_start  out  1  one-cycle pulse that starts the datapath.
- gen_abort  out  1  one-cycle pulse that stops the datapath.
- busy  out  1  high in RUN and FIN.
- done  out  1  one-cycle pulse when price updates.
- price  out  PAY_W  last completed mean payoff.

## Operation
- Registers:
  - cfg_spot (addr 0), cfg_strike (addr 1), cfg_vol (addr 2), log2_paths (addr 3, low bits only).
  - 2-bit load pointer.
- LOAD in IDLE:
  - Writes cfg_in to the register at the load pointer.
  - Pointer increments and wraps 3→0.
  - LOAD in any other state is ignored; the pointer does not move.
- Effective log2 n_eff = clamp(log2_paths, LG_L, LOG2_MAX). Beat target B = 2^(n_eff−LG_L).
- Accumulator width ACC_W = PAY_W + LOG2_MAX. The sum cannot overflow after clamping.
- FSM states IDLE, RUN, FIN:
  - IDLE + START → RUN. acc←0, beat counter←0, gen_start=1 for the first RUN cycle. Load pointer resets to 0.
  - RUN + pay_valid:
    - acc += sum of all LANES lanes (combinational adder tree, zero-extended).
    - counter++.
    - When counter==B−1 on an accepted beat → FIN.
  - pay_valid outside RUN is ignored.
  - RUN + ABORT → IDLE. gen_abort=1 for one cycle. price unchanged, no done.
    - ABORT takes priority over a same-cycle pay_valid; that beat is dropped.
  - START in RUN/FIN is ignored. ABORT in IDLE/FIN is ignored.
  - FIN → IDLE unconditionally. price ← acc >> n_eff (truncating). done=1 in the following cycle.
- The mean of values ≤ 2^PAY_W−1 fits PAY_W bits, so no saturation is needed.
- Configuration registers hold their values across runs. n_eff is latched at START.

## Timing
- Reset values: all config registers 0, load pointer 0, state IDLE, acc 0, counter 0, price 0, gen_start 0, gen_abort 0, busy 0, done 0.
- All outputs are registered.
- START sampled in cycle t:
  - gen_start=1 and busy=1 in cycle t+1.
  - The first beat can be accepted in t+1.
- Final beat accepted in cycle k:
  - FIN in k+1.
  - price updated and done=1 in k+2, busy=0 in k+2.
  - A new START is accepted from k+2.
- Minimum run (B=1): START at t, beat at t+1, done at t+3.
- Gaps in pay_valid stall the count with no loss of data; there is no backpressure.
- ABORT sampled in cycle t (RUN): gen_abort=1 and busy=0 in t+1, IDLE in t+1.
- Asynchronous reset mid-run returns every output to its reset value immediately. No done is produced.

## Test plan
- Reset/load:
  - Check all outputs are 0 after reset.
  - LOAD 0x100, 0x0C8, 0x014, 0x004 → cfg_spot=0x100, cfg_strike=0x0C8, cfg_vol=0x014.
  - A fifth LOAD of 0x2AA overwrites cfg_spot.
- Nominal run, LANES=4, log2_paths=4 (B=4):
  - 4 beats, all lanes 100 → done at k+2, price=100.
  - gen_start was high exactly one cycle.
- Mixed data and gaps:
  - log2_paths=3 (B=2). Beats {10,20,30,40} and {0,0,0,65535}, separated by 3 idle cycles.
  - Required: price = 65635>>3 = 8204.
- Clamp:
  - log2_paths=0 → B=1. One beat {1,2,3,4} → price = 10>>2 = 2, done at START+3.
  - log2_paths=31 → n_eff=16 and B=16384 beats are required.
- Abort:
  - ABORT after 2 of 4 beats, with pay_valid high in the same cycle.
  - Required: gen_abort one cycle, no done, price keeps its previous value.
  - A new run afterwards starts from acc=0 and gives the correct result.
- Illegal commands:
  - LOAD and START during RUN are ignored (config registers unchanged, no second gen_start).
  - pay_valid in IDLE does not affect the next result.
  - rst_n low mid-run clears busy/price with no done.

Source files
------------

// File: rtl/mc_pricing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_pricing_ctrl
// Purpose  : Control and accumulation core for the Monte-Carlo option-pricing
//            engine. Loads the pricing configuration over a narrow command/data
//            port and starts the path-generation datapath. Accumulates LANES
//            payoffs per beat over 2^n_eff paths and returns their mean as the
//            option price.
// Revision : 1.0 - initial lane-parallel controller with abort and done
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   cmd        in   00 NOP, 01 LOAD, 10 START, 11 ABORT
//   cfg_in     in   LOAD data word
//   pay_valid  in   all payoff lanes valid this cycle
//   pay_data   in   LANES unsigned payoffs, lane i at [i*PAY_W +: PAY_W]
//   cfg_spot   out  configuration register, address 0
//   cfg_strike out  configuration register, address 1
//   cfg_vol    out  configuration register, address 2
//   gen_start  out  one-cycle datapath start pulse
//   gen_abort  out  one-cycle datapath abort pulse
//   busy       out  high while a run is in progress (RUN or FIN)
//   done       out  one-cycle pulse when price updates
//   price      out  last completed mean payoff
// ============================================================================
module mc_pricing_ctrl #(
  parameter int LANES    = 4,
  parameter int IN_W     = 12,
  parameter int PAY_W    = 16,
  parameter int LOG2_MAX = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             cmd,
  input  logic [IN_W-1:0]        cfg_in,
  input  logic                   pay_valid,
  input  logic [LANES*PAY_W-1:0] pay_data,
  output logic [IN_W-1:0]        cfg_spot,
  output logic [IN_W-1:0]        cfg_strike,
  output logic [IN_W-1:0]        cfg_vol,
  output logic                   gen_start,
  output logic                   gen_abort,
  output logic                   busy,
  output logic                   done,
  output logic [PAY_W-1:0]       price
);

  localparam int LG_L  = $clog2(LANES);
  localparam int ACC_W = PAY_W + LOG2_MAX;
  // Wide enough to hold LOG2_MAX itself, so over-range requests can be clamped.
  localparam int N_W   = $clog2(LOG2_MAX + 1);
  // Beat counter must hold B-1 = 2^(LOG2_MAX-LG_L)-1 even when LANES = 1.
  localparam int CNT_W = LOG2_MAX + 1;
  localparam int SUM_W = PAY_W + LG_L;

  localparam logic [1:0] c_cmd_nop   = 2'b00;
  localparam logic [1:0] c_cmd_load  = 2'b01;
  localparam logic [1:0] c_cmd_start = 2'b10;
  localparam logic [1:0] c_cmd_abort = 2'b11;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_fin  = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [1:0]       ptr_q,       ptr_d;
  logic [IN_W-1:0]  spot_q,      spot_d;
  logic [IN_W-1:0]  strike_q,    strike_d;
  logic [IN_W-1:0]  vol_q,       vol_d;
  logic [N_W-1:0]   lg2_q,       lg2_d;
  logic [N_W-1:0]   n_eff_q,     n_eff_d;
  logic [ACC_W-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [PAY_W-1:0] price_q,     price_d;
  logic             gen_start_q, gen_start_d;
  logic             gen_abort_q, gen_abort_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;

  logic [N_W-1:0]   n_clamp;
  logic [CNT_W-1:0] beat_last;
  logic [SUM_W-1:0] beat_sum;
  logic [PAY_W-1:0] lane_w [LANES];

  // Unpack the flat payoff bus into one word per lane.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_w[gi] = pay_data[gi*PAY_W +: PAY_W];
  end

  // Zero-extended sum of all lanes; SUM_W carries the LG_L growth bits.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + SUM_W'(lane_w[i]);
    end
  end

  // Path count is clamped so at least one full beat is needed and the
  // accumulator can never overflow.
  always_comb begin
    if (lg2_q < N_W'(LG_L)) begin
      n_clamp = N_W'(LG_L);
    end else if (lg2_q > N_W'(LOG2_MAX)) begin
      n_clamp = N_W'(LOG2_MAX);
    end else begin
      n_clamp = lg2_q;
    end
  end

  assign beat_last = (CNT_W'(1) << (n_eff_q - N_W'(LG_L))) - CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    spot_d      = spot_q;
    strike_d    = strike_q;
    vol_d       = vol_q;
    lg2_d       = lg2_q;
    n_eff_d     = n_eff_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    price_d     = price_q;
    gen_start_d = 1'b0;
    gen_abort_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      c_st_idle: begin
        if (cmd == c_cmd_load) begin
          case (ptr_q)
            2'd0:    spot_d   = cfg_in;
            2'd1:    strike_d = cfg_in;
            2'd2:    vol_d    = cfg_in;
            default: lg2_d    = cfg_in[N_W-1:0];
          endcase
          ptr_d = ptr_q + 2'd1;
        end else if (cmd == c_cmd_start) begin
          state_d     = c_st_run;
          acc_d       = '0;
          cnt_d       = '0;
          ptr_d       = 2'd0;
          n_eff_d     = n_clamp;
          gen_start_d = 1'b1;
        end
      end
      c_st_run: begin
        // Abort wins over a coincident beat; that beat is discarded.
        if (cmd == c_cmd_abort) begin
          state_d     = c_st_idle;
          gen_abort_d = 1'b1;
        end else if (pay_valid) begin
          acc_d = acc_q + ACC_W'(beat_sum);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == beat_last) begin
            state_d = c_st_fin;
          end
        end
      end
      c_st_fin: begin
        state_d = c_st_idle;
        price_d = PAY_W'(acc_q >> n_eff_q);
        done_d  = 1'b1;
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase

    busy_d = (state_d == c_st_run) || (state_d == c_st_fin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= c_st_idle;
      ptr_q       <= 2'd0;
      spot_q      <= '0;
      strike_q    <= '0;
      vol_q       <= '0;
      lg2_q       <= '0;
      n_eff_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      price_q     <= '0;
      gen_start_q <= 1'b0;
      gen_abort_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      spot_q      <= spot_d;
      strike_q    <= strike_d;
      vol_q       <= vol_d;
      lg2_q       <= lg2_d;
      n_eff_q     <= n_eff_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      price_q     <= price_d;
      gen_start_q <= gen_start_d;
      gen_abort_q <= gen_abort_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cfg_spot   = spot_q;
  assign cfg_strike = strike_q;
  assign cfg_vol    = vol_q;
  assign gen_start  = gen_start_q;
  assign gen_abort  = gen_abort_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign price      = price_q;

  // cmd encoding kept complete for readability of the decode above.
  logic unused_w;
  assign unused_w = ^c_cmd_nop;

endmodule
`default_nettype wire

// File: tb/tb_mc_pricing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_pricing_ctrl
// Purpose  : Self-checking bench for mc_pricing_ctrl (LANES=4, PAY_W=16).
//            Expected prices come from a reference model that averages the
//            queued payoffs directly.
// Revision : 1.0 - initial bench
// ============================================================================
module tb_mc_pricing_ctrl;

  localparam int LANES = 4;
  localparam int IN_W = 12;
  localparam int PAY_W = 16;
  localparam int LOG2_MAX = 16;

  localparam logic [1:0] NOP = 2'b00, LOAD = 2'b01, START = 2'b10, ABORT = 2'b11;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [1:0]             cmd = NOP;
  logic [IN_W-1:0]        cfg_in = '0;
  logic                   pay_valid = 1'b0;
  logic [LANES*PAY_W-1:0] pay_data = '0;
  logic [IN_W-1:0]        cfg_spot, cfg_strike, cfg_vol;
  logic                   gen_start, gen_abort, busy, done;
  logic [PAY_W-1:0]       price;

  mc_pricing_ctrl #(.LANES(LANES), .IN_W(IN_W), .PAY_W(PAY_W), .LOG2_MAX(LOG2_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cfg_in(cfg_in),
    .pay_valid(pay_valid), .pay_data(pay_data),
    .cfg_spot(cfg_spot), .cfg_strike(cfg_strike), .cfg_vol(cfg_vol),
    .gen_start(gen_start), .gen_abort(gen_abort), .busy(busy),
    .done(done), .price(price)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] beat_q[$];

  // Results of the most recent run_queue call.
  int          r_gs, r_early, r_lat, r_busy_start, r_busy_at_done, r_done_after;
  logic [15:0] r_price;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int model_neff(input int lp);
    if (lp < 2) return 2;
    if (lp > LOG2_MAX) return LOG2_MAX;
    return lp;
  endfunction

  function automatic int model_beats(input int lp);
    return 1 << (model_neff(lp) - 2);
  endfunction

  function automatic longint model_price(input int lp);
    longint s = 0;
    foreach (beat_q[b]) begin
      for (int i = 0; i < LANES; i++) s += longint'(beat_q[b][i*16 +: 16]);
    end
    return s >> model_neff(lp);
  endfunction

  function automatic logic [63:0] rand_beat();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- drivers ----------------
  task automatic do_load(input logic [IN_W-1:0] v);
    cmd = LOAD; cfg_in = v;
    tick();
    cmd = NOP;
  endtask

  task automatic load_all(input logic [IN_W-1:0] s, k, v, lp);
    do_load(s); do_load(k); do_load(v); do_load(lp);
  endtask

  task automatic fill_random(input int n);
    beat_q.delete();
    for (int i = 0; i < n; i++) beat_q.push_back(rand_beat());
  endtask

  // Runs one START, feeds beat_q with gaps, and records handshake timing.
  // With illegal set, LOAD/START are issued during RUN cycles.
  task automatic run_queue(input int gap, input bit rand_gap, input bit illegal);
    r_gs = 0; r_early = 0; r_lat = -1; r_busy_at_done = -1; r_done_after = -1;
    cmd = START;
    tick();
    cmd = NOP;
    r_busy_start = int'(busy);
    if (gen_start) r_gs++;
    for (int b = 0; b < beat_q.size(); b++) begin
      int g;
      g = (b == 0) ? 0 : (rand_gap ? int'($urandom_range(0, gap)) : gap);
      for (int i = 0; i < g; i++) begin
        pay_valid = 1'b0; pay_data = rand_beat();
        if (illegal) begin cmd = ($urandom_range(0, 1) != 0) ? LOAD : START; cfg_in = IN_W'($urandom()); end
        tick();
        cmd = NOP;
        if (gen_start) r_gs++;
        if (done) r_early++;
      end
      pay_valid = 1'b1; pay_data = beat_q[b];
      if (illegal) begin cmd = ($urandom_range(0, 1) != 0) ? LOAD : START; cfg_in = IN_W'($urandom()); end
      tick();
      cmd = NOP;
      if (gen_start) r_gs++;
      if (done && b != beat_q.size() - 1) r_early++;
    end
    pay_valid = 1'b0;
    pay_data = rand_beat();
    for (int i = 2; i <= 12; i++) begin
      tick();
      if (gen_start) r_gs++;
      if (done) begin r_lat = i; r_price = price; r_busy_at_done = int'(busy); break; end
    end
    if (r_lat > 0) begin
      tick();
      r_done_after = int'(done);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++;
    if ({cfg_spot, cfg_strike, cfg_vol, gen_start, gen_abort, busy, done, price} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got spot=%h strike=%h vol=%h gs=%b ga=%b busy=%b done=%b price=%0d want all 0",
               cfg_spot, cfg_strike, cfg_vol, gen_start, gen_abort, busy, done, price);
    end
  endtask

  task automatic test_load();
    load_all(12'h100, 12'h0C8, 12'h014, 12'h004);
    n_cmp++;
    if ({cfg_spot, cfg_strike, cfg_vol} !== {12'h100, 12'h0C8, 12'h014}) begin
      n_bad++;
      $display("FAIL load_regs got %h/%h/%h want 100/0c8/014", cfg_spot, cfg_strike, cfg_vol);
    end
    do_load(12'h2AA);
    n_cmp++;
    if (cfg_spot !== 12'h2AA || cfg_strike !== 12'h0C8) begin
      n_bad++;
      $display("FAIL load_wrap got spot=%h strike=%h want spot=2aa strike=0c8", cfg_spot, cfg_strike);
    end
    // Walk the pointer back to 0.
    do_load(12'h0C8); do_load(12'h014); do_load(12'h004);
  endtask

  task automatic test_nominal();
    beat_q.delete();
    for (int i = 0; i < 4; i++) beat_q.push_back({4{16'd100}});
    run_queue(0, 1'b0, 1'b0);
    n_cmp++;
    if (r_price !== 16'(model_price(4)) || r_lat != 2) begin
      n_bad++;
      $display("FAIL nominal_price got price=%0d lat=%0d want price=%0d lat=2", r_price, r_lat, model_price(4));
    end
    n_cmp++;
    if (r_gs != 1 || r_busy_start != 1 || r_early != 0) begin
      n_bad++;
      $display("FAIL nominal_handshake got gs=%0d busy=%0d early_done=%0d want 1/1/0", r_gs, r_busy_start, r_early);
    end
    n_cmp++;
    if (r_busy_at_done != 0 || r_done_after != 0) begin
      n_bad++;
      $display("FAIL nominal_done_pulse got busy@done=%0d done_next=%0d want 0/0", r_busy_at_done, r_done_after);
    end
  endtask

  task automatic test_gaps();
    load_all(12'h100, 12'h0C8, 12'h014, 12'h003);
    beat_q.delete();
    beat_q.push_back({16'd40, 16'd30, 16'd20, 16'd10});
    beat_q.push_back({16'd65535, 16'd0, 16'd0, 16'd0});
    run_queue(3, 1'b0, 1'b0);
    n_cmp++;
    if (r_price !== 16'(model_price(3)) || r_lat != 2 || r_early != 0) begin
      n_bad++;
      $display("FAIL gaps_price got price=%0d lat=%0d early=%0d want price=%0d lat=2 early=0",
               r_price, r_lat, r_early, model_price(3));
    end
  endtask

  task automatic test_clamp();
    load_all(12'h100, 12'h0C8, 12'h014, 12'h000);
    beat_q.delete();
    beat_q.push_back({16'd4, 16'd3, 16'd2, 16'd1});
    run_queue(0, 1'b0, 1'b0);
    n_cmp++;
    if (r_price !== 16'(model_price(0)) || r_lat != 2) begin
      n_bad++;
      $display("FAIL clamp_low got price=%0d lat=%0d want price=%0d lat=2", r_price, r_lat, model_price(0));
    end
    load_all(12'h100, 12'h0C8, 12'h014, 12'h01F);
    fill_random(model_beats(31));
    run_queue(0, 1'b0, 1'b0);
    n_cmp++;
    if (r_price !== 16'(model_price(31)) || r_lat != 2 || r_early != 0) begin
      n_bad++;
      $display("FAIL clamp_high got price=%0d lat=%0d early=%0d want price=%0d lat=2 early=0",
               r_price, r_lat, r_early, model_price(31));
    end
  endtask

  task automatic test_abort();
    load_all(12'h100, 12'h0C8, 12'h014, 12'h004);
    for (int nb = 2; nb <= 3; nb++) begin
      logic [15:0] prev;
      int ga_cnt, dn_cnt;
      prev = price; ga_cnt = 0; dn_cnt = 0;
      cmd = START; tick(); cmd = NOP;
      for (int b = 0; b < nb; b++) begin
        pay_valid = 1'b1; pay_data = rand_beat(); tick();
      end
      cmd = ABORT; pay_valid = 1'b1; pay_data = rand_beat();
      tick();
      cmd = NOP; pay_valid = 1'b0;
      n_cmp++;
      if (gen_abort !== 1'b1 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_pulse nb=%0d got ga=%b busy=%b want 1/0", nb, gen_abort, busy);
      end
      for (int i = 0; i < 6; i++) begin
        tick();
        if (gen_abort) ga_cnt++;
        if (done) dn_cnt++;
      end
      n_cmp++;
      if (ga_cnt != 0 || dn_cnt != 0 || price !== prev) begin
        n_bad++;
        $display("FAIL abort_after nb=%0d got extra_ga=%0d done=%0d price=%0d want 0/0/%0d",
                 nb, ga_cnt, dn_cnt, price, prev);
      end
    end
    fill_random(4);
    run_queue(1, 1'b1, 1'b0);
    n_cmp++;
    if (r_price !== 16'(model_price(4)) || r_lat != 2) begin
      n_bad++;
      $display("FAIL abort_rerun got price=%0d lat=%0d want price=%0d lat=2", r_price, r_lat, model_price(4));
    end
  endtask

  task automatic test_illegal();
    load_all(12'h123, 12'h456, 12'h789, 12'h005);
    // Beats presented while idle must not reach the accumulator.
    for (int i = 0; i < 3; i++) begin
      pay_valid = 1'b1; pay_data = {4{16'hFFFF}}; tick();
    end
    pay_valid = 1'b0;
    fill_random(model_beats(5));
    run_queue(2, 1'b1, 1'b1);
    n_cmp++;
    if (r_price !== 16'(model_price(5)) || r_lat != 2 || r_gs != 1) begin
      n_bad++;
      $display("FAIL illegal_run got price=%0d lat=%0d gs=%0d want price=%0d lat=2 gs=1",
               r_price, r_lat, r_gs, model_price(5));
    end
    n_cmp++;
    if ({cfg_spot, cfg_strike, cfg_vol} !== {12'h123, 12'h456, 12'h789}) begin
      n_bad++;
      $display("FAIL illegal_cfg got %h/%h/%h want 123/456/789", cfg_spot, cfg_strike, cfg_vol);
    end
    // Pointer must still be at 0 after the run.
    load_all(12'h321, 12'h654, 12'h987, 12'h002);
    n_cmp++;
    if ({cfg_spot, cfg_strike, cfg_vol} !== {12'h321, 12'h654, 12'h987}) begin
      n_bad++;
      $display("FAIL illegal_ptr got %h/%h/%h want 321/654/987", cfg_spot, cfg_strike, cfg_vol);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [IN_W-1:0] s, k, v;
      int lp;
      s = IN_W'($urandom()); k = IN_W'($urandom()); v = IN_W'($urandom());
      lp = int'($urandom_range(0, 7));
      load_all(s, k, v, IN_W'(lp));
      fill_random(model_beats(lp));
      run_queue(2, 1'b1, it[0]);
      n_cmp++;
      if (r_price !== 16'(model_price(lp)) || r_lat != 2 || r_gs != 1 || r_early != 0) begin
        n_bad++;
        $display("FAIL random_run it=%0d lp=%0d got price=%0d lat=%0d gs=%0d early=%0d want price=%0d lat=2 gs=1 early=0",
                 it, lp, r_price, r_lat, r_gs, r_early, model_price(lp));
      end
      n_cmp++;
      if ({cfg_spot, cfg_strike, cfg_vol} !== {s, k, v}) begin
        n_bad++;
        $display("FAIL random_cfg it=%0d got %h/%h/%h want %h/%h/%h", it, cfg_spot, cfg_strike, cfg_vol, s, k, v);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int dn_cnt;
    dn_cnt = 0;
    load_all(12'h111, 12'h222, 12'h333, 12'h002);
    cmd = START; tick(); cmd = NOP;
    pay_valid = 1'b1; pay_data = rand_beat(); tick();
    pay_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cfg_spot, cfg_strike, cfg_vol, gen_start, gen_abort, busy, done, price} !== '0) begin
      n_bad++;
      $display("FAIL reset_midrun got busy=%b done=%b price=%0d spot=%h want all 0", busy, done, price, cfg_spot);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done || busy) dn_cnt++;
    end
    n_cmp++;
    if (dn_cnt != 0) begin
      n_bad++;
      $display("FAIL reset_no_done got active_cycles=%0d want 0", dn_cnt);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_load();
    test_nominal();
    test_gaps();
    test_clamp();
    test_abort();
    test_illegal();
    test_random();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
